// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multi-cycle controller that fetches 16-bit instructions from a synchronous
// instruction ROM and sequences the Datapath (data memory, register file, ALU,
// writeback mux). Owns the program counter and the instruction register.
//
// Ports:
//   Clock       in   system clock, all state updates on the rising edge
//   ResetN      in   synchronous active-low reset
//   I_Data      in   instruction-ROM read data (one cycle after PC_Addr)
//   PC_Addr     out  instruction-ROM address (the PC register)
//   D_Addr      out  data-memory address
//   D_Wr        out  data-memory write enable
//   RF_s        out  writeback select (0 = ALU, 1 = memory)
//   RF_W_Addr   out  register-file write address
//   RF_W_en     out  register-file write enable
//   RF_Ra_Addr  out  register-file A read address
//   RF_Rb_Addr  out  register-file B read address
//   ALU_s0      out  ALU operation select
//   IR_Out      out  current instruction register (debug)
//   State       out  current FSM state encoding (debug)
//   Halted      out  high while in HALT
//
// Handshake: there is none. Every instruction takes a fixed number of cycles
// and the Datapath acts on the control outputs in the cycle they are driven.
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int         PC_WIDTH = 7,
    parameter logic [2:0] ALU_PASS = 3'd0,
    parameter logic [2:0] ALU_ADD  = 3'd1,
    parameter logic [2:0] ALU_SUB  = 3'd2
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic [15:0]         I_Data,
    output logic [PC_WIDTH-1:0] PC_Addr,
    output logic [7:0]          D_Addr,
    output logic                D_Wr,
    output logic                RF_s,
    output logic [3:0]          RF_W_Addr,
    output logic                RF_W_en,
    output logic [3:0]          RF_Ra_Addr,
    output logic [3:0]          RF_Rb_Addr,
    output logic [2:0]          ALU_s0,
    output logic [15:0]         IR_Out,
    output logic [3:0]          State,
    output logic                Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         ir_q;

    logic [3:0] op;
    assign op = ir_q[15:12];

    // Sequencing: state, PC and IR all live in this one block.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            case (state_q)
                // INIT gives the ROM one cycle to present the word at PC=0.
                S_INIT:   state_q <= S_FETCH;
                S_FETCH: begin
                    ir_q    <= I_Data;
                    pc_q    <= pc_q + 1'b1;  // natural wrap at 2^PC_WIDTH
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        4'b0001: state_q <= S_STORE;
                        4'b0010: state_q <= S_LOAD_A;
                        4'b0011: state_q <= S_ADD;
                        4'b0100: state_q <= S_SUB;
                        4'b0101: state_q <= S_HALT;
                        default: state_q <= S_NOOP;  // 0000 and 0110-1111
                    endcase
                end
                S_LOAD_A: state_q <= S_LOAD_B;
                S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_INIT;  // unused encodings recover
            endcase
        end
    end

    // Control decode from registered state and IR.
    logic d_wr_raw;
    logic rf_w_en_raw;

    always_comb begin
        D_Addr      = 8'h00;
        d_wr_raw    = 1'b0;
        RF_s        = 1'b0;
        RF_W_Addr   = 4'h0;
        rf_w_en_raw = 1'b0;
        RF_Ra_Addr  = 4'h0;
        RF_Rb_Addr  = 4'h0;
        ALU_s0      = ALU_PASS;
        case (state_q)
            S_LOAD_A, S_LOAD_B: begin
                D_Addr      = ir_q[11:4];
                RF_s        = 1'b1;
                RF_W_Addr   = ir_q[3:0];
                // LOAD_A only waits out the memory read latency.
                rf_w_en_raw = (state_q == S_LOAD_B);
            end
            S_STORE: begin
                D_Addr     = ir_q[11:4];
                RF_Ra_Addr = ir_q[3:0];
                d_wr_raw   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr  = ir_q[11:8];
                RF_Rb_Addr  = ir_q[7:4];
                RF_W_Addr   = ir_q[3:0];
                rf_w_en_raw = 1'b1;
                ALU_s0      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    // Gating the strobes with ResetN keeps a reset edge from committing a
    // half-finished LOAD or STORE.
    assign D_Wr    = d_wr_raw & ResetN;
    assign RF_W_en = rf_w_en_raw & ResetN;

    assign PC_Addr = pc_q;
    assign IR_Out  = ir_q;
    assign State   = state_q;
    assign Halted  = (state_q == S_HALT);

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM controller that sequences the Datapath block (data memory, register file, ALU, writeback mux) from a 16-bit instruction stream.
- Owns the program counter (PC) and instruction register (IR).
- Addresses a synchronous instruction ROM and drives every Datapath control input.
- Sits between the instruction ROM and Datapath inside the processor top level.

Parameters:
- PC_WIDTH, 7, width of PC and instruction-ROM address.
- ALU_PASS, 3'd0, ALU select driven when no operation is active.
- ALU_ADD, 3'd1, ALU select for ADD.
- ALU_SUB, 3'd2, ALU select for SUB.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- ResetN  input  1  synchronous, active-low reset.
- I_Data  input  16  instruction-ROM read data; valid one cycle after PC_Addr changes.
- PC_Addr  output  PC_WIDTH  instruction-ROM address (equals PC register).
- D_Addr  output  8  Datapath data-memory address.
- D_Wr  output  1  Datapath data-memory write enable.
- RF_s  output  1  writeback mux select (0 = ALU, 1 = memory).
- RF_W_Addr  output  4  register-file write address.
- RF_W_en  output  1  register-file write enable.
- RF_Ra_Addr  output  4  register-file A read address.
- RF_Rb_Addr  output  4  register-file B read address.
- ALU_s0  output  3  ALU operation select.
- IR_Out  output  16  current IR (debug).
- State  output  4  current FSM state encoding (debug).
- Halted  output  1  high while in HALT.

Behaviour:
- Reset is synchronous and active-low: ResetN sampled 0 on a rising edge gives State=INIT, PC=0, IR=0.
- D_Wr and RF_W_en are combinationally ANDed with ResetN, so no write commits on a reset edge, including reset mid-LOAD or mid-STORE.
- Outputs decode combinationally from registered State and IR. In any state not listed below, every control output is 0 and ALU_s0=ALU_PASS.
- Instruction format: op=IR[15:12].
  - STORE 0001: addr=IR[11:4], Ra=IR[3:0].
  - LOAD 0010: addr=IR[11:4], Rd=IR[3:0].
  - ADD 0011 / SUB 0100: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0].
  - NOOP 0000; HALT 0101.
  - Opcodes 0110-1111 decode as NOOP.
- State encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- INIT -> FETCH unconditionally; this cycle covers ROM latency for PC=0.
- FETCH: IR<=I_Data; PC<=PC+1, wrapping 2^PC_WIDTH-1 -> 0. Next state DECODE.
- DECODE: branch on op to NOOP/LOAD_A/STORE/ADD/SUB/HALT. No outputs asserted.
- NOOP -> FETCH.
- LOAD_A:
  - D_Addr=addr, RF_s=1, RF_W_addr=Rd, RF_W_en=0.
  - This cycle covers data-memory read latency. Next state LOAD_B.
- LOAD_B: D_Addr=addr, RF_s=1, RF_W_Addr=Rd, RF_W_en=1. Next state FETCH.
- STORE: D_Addr=addr, RF_Ra_Addr=Ra, D_Wr=1 for exactly one cycle. Next state FETCH.
- ADD: RF_Ra_Addr=Ra, RF_Rb_Addr=Rb, ALU_s0=ALU_ADD, RF_s=0, RF_W_Addr=Rd, RF_W_en=1 for one cycle. Next state FETCH.
- SUB: same as ADD with ALU_s0=ALU_SUB.
- HALT: self-loop, Halted=1, all strobes 0. PC and IR frozen. Only reset exits.
- Instruction cycle counts including FETCH and DECODE:
  - NOOP/STORE/ADD/SUB: 3 cycles.
  - LOAD: 4 cycles.
  - First FETCH occurs 1 cycle after reset release.
- ROM timing: PC changes only in FETCH, so I_Data is always settled ≥1 cycle before the next FETCH.
- Register-file read-after-write (Rd of instruction N = Ra/Rb of instruction N+1) needs no interlock. The write commits at the end of the execute cycle, at least two cycles before the next execute.
- Same-register source and destination (e.g. ADD R3,R3->R3): reads use old value; write occurs at the end of the cycle.
- Arithmetic is performed in Datapath; the controller does no data arithmetic except the PC increment.

Test Plan:
- Reset/INIT: hold ResetN=0 for 3 cycles, release -> State 0 then 1; PC_Addr=0; all strobes 0. Cycle after FETCH: IR_Out=I_Data and PC_Addr=1.
- LOAD: I_Data=16'h21AA (LOAD R10<-mem[0x1A]) -> LOAD_A with D_Addr=8'h1A, RF_s=1, RF_W_en=0. Then LOAD_B with RF_W_en=1, RF_W_Addr=4'hA. Back to FETCH after 4 cycles total.
- ADD then STORE:
  - Program 16'h3AB0 (ADD R10,R11->R0) -> one cycle with ALU_s0=1, RF_Ra_Addr=A, RF_Rb_Addr=B, RF_W_Addr=0, RF_W_en=1, RF_s=0.
  - Then 16'h1000 (STORE mem[0]<-R0) -> D_Wr=1 for exactly one cycle, D_Addr=0, RF_Ra_Addr=0.
  - Against a Datapath with mem[0x1A]=5 and mem[0x2B]=7, mem[0] reads 12.
- SUB/illegal opcode: 16'h4123 -> ALU_s0=2, RF_W_Addr=3. Opcode 4'hF -> NOOP path in 3 cycles, no strobes, PC advances.
- HALT and wrap:
  - HALT (16'h5000) -> Halted=1 and PC frozen for 20 cycles; reset returns State=0.
  - Separately, 128 NOOPs from PC=0: after the 128th FETCH, PC_Addr=0.
- Reset mid-operation: drive ResetN=0 during the LOAD_B cycle and during the STORE cycle. RF_W_en and D_Wr are 0 that cycle and no register/memory update occurs. Next state is INIT.
